// File: rtl/sv_net1_pkg.sv
// Shared definitions for the sv_net1 self-test: sweep FSM states, vector sizing
// and the golden xy response of the net for every abcd input.
package sv_net1_pkg;

    localparam int unsigned VECTOR_WIDTH = 4;
    localparam int unsigned NUM_VECTORS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } sweep_state_t;

    // Indexed by abcd; each entry is {x, y}.
    localparam logic [1:0] EXPECTED_XY [NUM_VECTORS] = '{
        2'b10, 2'b10, 2'b00, 2'b00,
        2'b11, 2'b11, 2'b01, 2'b01,
        2'b10, 2'b00, 2'b10, 2'b00,
        2'b11, 2'b11, 2'b11, 2'b11
    };

    function automatic logic [1:0] expected_xy(input logic [VECTOR_WIDTH-1:0] abcd);
        return EXPECTED_XY[abcd];
    endfunction

endpackage

// File: rtl/sv_net1_sweep_ctrl.sv
// Self-test sequencer: sweeps all abcd vectors into sv_net1, checks xy against the
// golden table after a settle delay, and reports pass, mismatch count and first failure.
module sv_net1_sweep_ctrl
    import sv_net1_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              net_xy,
    output logic [VECTOR_WIDTH-1:0] net_abcd,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [4:0]              error_count,
    output logic [VECTOR_WIDTH-1:0] first_fail,
    output logic                    first_fail_valid
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    sweep_state_t            state_q, state_d;
    logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
    logic [3:0]              settle_q, settle_d;
    logic [4:0]              error_count_q, error_count_d;
    logic [VECTOR_WIDTH-1:0] first_fail_q, first_fail_d;
    logic                    first_fail_valid_q, first_fail_valid_d;
    logic                    pass_q, pass_d;
    logic                    done_q, done_d;
    logic [VECTOR_WIDTH-1:0] net_abcd_q, net_abcd_d;

    always_comb begin
        state_d            = state_q;
        vector_d           = vector_q;
        settle_d           = settle_q;
        error_count_d      = error_count_q;
        first_fail_d       = first_fail_q;
        first_fail_valid_d = first_fail_valid_q;
        pass_d             = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d            = APPLY;
                    vector_d           = '0;
                    settle_d           = '0;
                    error_count_d      = '0;
                    first_fail_d       = '0;
                    first_fail_valid_d = 1'b0;
                    pass_d             = 1'b0;
                end
            end
            APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CHECK: begin
                if (net_xy != expected_xy(vector_q)) begin
                    error_count_d = error_count_q + 5'd1;
                    if (!first_fail_valid_q) begin
                        first_fail_d       = vector_q;
                        first_fail_valid_d = 1'b1;
                    end
                end
                // pass is taken from the updated count so it is already valid in DONE
                if (vector_q == '1) begin
                    state_d = DONE;
                    pass_d  = (error_count_d == '0);
                end else begin
                    vector_d = vector_q + 4'd1;
                    settle_d = '0;
                    state_d  = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they align with it.
        done_d     = (state_d == DONE);
        net_abcd_d = ((state_d == APPLY) || (state_d == CHECK)) ? vector_d : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            vector_q           <= '0;
            settle_q           <= '0;
            error_count_q      <= '0;
            first_fail_q       <= '0;
            first_fail_valid_q <= 1'b0;
            pass_q             <= 1'b0;
            done_q             <= 1'b0;
            net_abcd_q         <= '0;
        end else begin
            state_q            <= state_d;
            vector_q           <= vector_d;
            settle_q           <= settle_d;
            error_count_q      <= error_count_d;
            first_fail_q       <= first_fail_d;
            first_fail_valid_q <= first_fail_valid_d;
            pass_q             <= pass_d;
            done_q             <= done_d;
            net_abcd_q         <= net_abcd_d;
        end
    end

    assign busy             = (state_q == APPLY) || (state_q == CHECK);
    assign done             = done_q;
    assign pass             = pass_q;
    assign error_count      = error_count_q;
    assign first_fail       = first_fail_q;
    assign first_fail_valid = first_fail_valid_q;
    assign net_abcd         = net_abcd_q;

endmodule

// File: tb/tb_sv_net1_sweep_ctrl.sv
// Bench for sv_net1_sweep_ctrl: a behavioural net with injectable faults feeds two
// instances (settle 1 and 3); per-cycle and end-of-sweep expectations go through queues.
module tb_sv_net1_sweep_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       start1, start3;
    logic [1:0] xy1, xy3;
    logic [3:0] abcd1, abcd3, ff1, ff3;
    logic       busy1, busy3, done1, done3, pass1, pass3, ffv1, ffv3;
    logic [4:0] err1, err3;
    int         fault1 = 0, fault3 = 0;

    int checks   = 0;
    int failures = 0;

    logic [1:0] golden [16] = '{
        2'b10, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 2'b01,
        2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11
    };

    // fault 1: y stuck at 0; 2: x flipped on vectors 3 and 9; 3: both bits inverted
    function automatic logic [1:0] net_model(input logic [3:0] abcd, input int fault);
        logic [1:0] g;
        g = golden[abcd];
        case (fault)
            1: g[0] = 1'b0;
            2: if (abcd == 4'd3 || abcd == 4'd9) g[1] = ~g[1];
            3: g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    always_comb xy1 = net_model(abcd1, fault1);
    always_comb xy3 = net_model(abcd3, fault3);

    sv_net1_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .net_xy(xy1),
        .net_abcd(abcd1), .busy(busy1), .done(done1), .pass(pass1),
        .error_count(err1), .first_fail(ff1), .first_fail_valid(ffv1)
    );

    sv_net1_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(start3), .net_xy(xy3),
        .net_abcd(abcd3), .busy(busy3), .done(done3), .pass(pass3),
        .error_count(err3), .first_fail(ff3), .first_fail_valid(ffv3)
    );

    typedef struct {
        logic [3:0] abcd;
        logic       busy;
        logic       done;
    } cyc_t;

    typedef struct {
        logic       pass;
        logic [4:0] err;
        logic [3:0] ff;
        logic       ffv;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];

    task automatic run_sweep(input bit sel3, input int fault, input bit keep_start);
        int   s;
        int   n;
        res_t r;
        cyc_t c;
        cyc_t e;
        logic [3:0] a, f;
        logic b, d, p, fv;
        logic [4:0] ec;
        s = sel3 ? 3 : 1;
        if (sel3) fault3 = fault; else fault1 = fault;
        r.err = '0; r.ff = '0; r.ffv = 1'b0;
        for (int v = 0; v < 16; v++) begin
            if (net_model(4'(v), fault) !== golden[v]) begin
                r.err = r.err + 5'd1;
                if (!r.ffv) begin
                    r.ff  = 4'(v);
                    r.ffv = 1'b1;
                end
            end
        end
        r.pass = (r.err == 5'd0);
        res_q.push_back(r);
        for (int v = 0; v < 16; v++) begin
            c.abcd = 4'(v); c.busy = 1'b1; c.done = 1'b0;
            repeat (s + 1) cyc_q.push_back(c);
        end
        c.abcd = 4'd0; c.busy = 1'b0; c.done = 1'b1;
        cyc_q.push_back(c);

        @(negedge clock);
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clock);
        n = 0;
        while (cyc_q.size() > 0) begin
            @(negedge clock);
            n++;
            if (!keep_start) begin
                if (sel3) start3 = 1'b0; else start1 = 1'b0;
            end
            e  = cyc_q.pop_front();
            a  = sel3 ? abcd3 : abcd1;
            b  = sel3 ? busy3 : busy1;
            d  = sel3 ? done3 : done1;
            p  = sel3 ? pass3 : pass1;
            ec = sel3 ? err3  : err1;
            f  = sel3 ? ff3   : ff1;
            fv = sel3 ? ffv3  : ffv1;
            checks++;
            if (a !== e.abcd || b !== e.busy || d !== e.done) begin
                failures++;
                $display("FAIL sweep_cycle settle=%0d fault=%0d k+%0d: abcd=%h busy=%b done=%b, required abcd=%h busy=%b done=%b",
                         s, fault, n, a, b, d, e.abcd, e.busy, e.done);
            end
            if (e.done) begin
                r = res_q.pop_front();
                checks++;
                if (p !== r.pass || ec !== r.err || f !== r.ff || fv !== r.ffv) begin
                    failures++;
                    $display("FAIL sweep_result settle=%0d fault=%0d: pass=%b err=%0d ff=%h ffv=%b, required pass=%b err=%0d ff=%h ffv=%b",
                             s, fault, p, ec, f, fv, r.pass, r.err, r.ff, r.ffv);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (abcd1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 ||
            err1 !== 5'd0 || ff1 !== 4'd0 || ffv1 !== 1'b0 ||
            abcd3 !== 4'd0 || busy3 !== 1'b0 || done3 !== 1'b0 || pass3 !== 1'b0 ||
            err3 !== 5'd0 || ff3 !== 4'd0 || ffv3 !== 1'b0) begin
            failures++;
            $display("FAIL %s: dut1 abcd=%h busy=%b done=%b pass=%b err=%0d ff=%h ffv=%b dut3 abcd=%h busy=%b done=%b pass=%b err=%0d ff=%h ffv=%b, required all zero",
                     name, abcd1, busy1, done1, pass1, err1, ff1, ffv1,
                     abcd3, busy3, done3, pass3, err3, ff3, ffv3);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start1  = 1'b1;
        start3  = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_all_zero("reset_hold");
        end
        reset_n = 1'b1;
        start1  = 1'b0;
        start3  = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_all_zero("reset_release_idle");
        end
    endtask

    task automatic test_golden();
        run_sweep(1'b0, 0, 1'b0);
    endtask

    task automatic test_stuck_y();
        run_sweep(1'b0, 1, 1'b0);
    endtask

    task automatic test_first_fail_kept();
        run_sweep(1'b0, 2, 1'b0);
    endtask

    task automatic test_all_mismatch();
        run_sweep(1'b0, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sweep(1'b0, 1, 1'b1);
        @(negedge clock);
        checks++;
        if (busy1 !== 1'b0 || abcd1 !== 4'd0 || done1 !== 1'b0 || err1 !== 5'd8 ||
            ff1 !== 4'd4 || ffv1 !== 1'b1 || pass1 !== 1'b0) begin
            failures++;
            $display("FAIL held_start_idle: busy=%b abcd=%h done=%b err=%0d ff=%h ffv=%b pass=%b, required 0 0 0 8 4 1 0",
                     busy1, abcd1, done1, err1, ff1, ffv1, pass1);
        end
        @(negedge clock);
        checks++;
        if (busy1 !== 1'b1 || abcd1 !== 4'd0 || done1 !== 1'b0 || err1 !== 5'd0 ||
            ff1 !== 4'd0 || ffv1 !== 1'b0 || pass1 !== 1'b0) begin
            failures++;
            $display("FAIL held_start_restart: busy=%b abcd=%h done=%b err=%0d ff=%h ffv=%b pass=%b, required 1 0 0 0 0 0 0",
                     busy1, abcd1, done1, err1, ff1, ffv1, pass1);
        end
        start1  = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_sweep();
        int waited;
        fault1 = 0;
        @(negedge clock);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        waited = 0;
        while (abcd1 !== 4'd7 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (abcd1 !== 4'd7) begin
            failures++;
            $display("FAIL mid_sweep_reach7: abcd=%h after %0d cycles, required 7", abcd1, waited);
        end
        reset_n = 1'b0;
        @(negedge clock);
        check_all_zero("mid_sweep_reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("mid_sweep_after_release");
        run_sweep(1'b0, 0, 1'b0);
    endtask

    task automatic test_settle3();
        run_sweep(1'b1, 0, 1'b0);
        run_sweep(1'b1, 1, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        start1  = 1'b0;
        start3  = 1'b0;
        test_reset();
        test_golden();
        test_stuck_y();
        test_first_fail_kept();
        test_all_mismatch();
        test_back_to_back();
        test_reset_mid_sweep();
        test_settle3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
